ws2811_receiver: RTL and testbench
==================================

// Module: ws2811_receiver
// PURPOSE
//  Decodes a WS2811 single-wire NRZ pixel stream into 24-bit words (MSB first). Counterpart of the
//  WS2811 transmitter: used as loopback checker for the LED driver and as input stage for a
//  pixel-sniffer/repeater. Sits between an input pin and the frame-buffer/host logic.
// PARAMETERS
//  CLOCK_SPEED      50_000_000  clkIN frequency, Hz (multiple of 1 MHz)
//  BIT_THRESH_NS    850         high time > threshold -> bit 1, else bit 0
//  MIN_HIGH_NS      200         high pulse shorter than this -> error
//  MAX_HIGH_NS      2000        high pulse longer than this -> error
//  RESET_NS         50_000      low time >= this -> latch (frame end)
//  Derived clocks: X_CLK = (CLOCK_SPEED/1_000_000)*X_NS/1000 (defaults: 42, 10, 100, 2500)
// PORTS
//  clkIN        in   1   system clock, all logic on posedge
//  nResetIN     in   1   asynchronous active-low reset
//  dataIN       in   1   raw serial line (asynchronous to clkIN)
//  dataOUT      out  24  last complete word, MSB = first bit received
//  validOUT     out  1   1-cycle pulse: dataOUT updated
//  latchOUT     out  1   1-cycle pulse: reset gap detected
//  errorOUT     out  1   1-cycle pulse: malformed pulse / partial word discarded
//  busyOUT      out  1   high while in frame (RX_LOW/RX_HIGH)
//  forwardOUT   out  1   only with WS2811_RX_FORWARD_EN (see CONFIGURATION)
// BEHAVIOUR
//  - Reset: all outputs 0, bit counter 0, pulse counter 0, state SYNC, sync flops 0.
//  - dataIN passes a 2-FF synchroniser; edges detected on synced signal vs. 1-cycle delayed copy.
//  - 16-bit pulse counter, saturating at all-ones, cleared on every synced edge.
//  - States:
//    SYNC    : wait for line low >= RESET_CLK; then -> IDLE (no latchOUT). Line high restarts count.
//    IDLE    : rising edge -> RX_HIGH.
//    RX_HIGH : on falling edge: cnt < MIN_HIGH_CLK or cnt > MAX_HIGH_CLK -> errorOUT, -> SYNC;
//              else shift bit (cnt > BIT_THRESH_CLK) into shift reg, bitCnt+1, -> RX_LOW.
//              cnt exceeding MAX_HIGH_CLK while still high: errorOUT once, -> SYNC.
//    RX_LOW  : rising edge -> RX_HIGH; cnt reaching RESET_CLK -> latchOUT, -> IDLE.
//  - bitCnt 0..23; on 24th accepted bit: dataOUT <= shift reg, validOUT pulse, bitCnt wraps to 0.
//  - validOUT asserted exactly 3 clkIN after the dataIN falling edge (2 sync + 1 decode).
//  - Latch with bitCnt != 0: latchOUT and errorOUT pulse same cycle, partial bits dropped,
//    dataOUT unchanged.
//  - Any error clears bitCnt; dataOUT holds last good word.
//  - Exactly one of validOUT/latchOUT per cycle can fire from timing; error may coincide with latch.
//  - Reset mid-frame: immediate clear, restart in SYNC (first frame after reset needs a gap).
// CONFIGURATION
//  WS2811_RX_FORWARD_EN defined: daisy-chain repeater. First word of each frame consumed;
//   following bits regenerated on forwardOUT: high BIT_THRESH? 1200 ns : 500 ns from decoded
//   value, started on each rising edge after word 0; line forced low in SYNC/IDLE, after latch,
//   and on error. Forwarded output lags input by 3 clk.
//  Not defined: forwardOUT port absent, every word reported via validOUT.
// TESTING
//  1. Reset release, line low 60 us, frame 0xA5C3F0 (0=500/2000 ns, 1=1200/1300 ns) ->
//     validOUT once, dataOUT=0xA5C3F0, latchOUT 2500 clk after last falling edge.
//  2. Two words 0xFFFFFF,0x000001 then gap -> two validOUT, values in order, one latchOUT.
//  3. 12 bits then 60 us low -> latchOUT+errorOUT same cycle, dataOUT unchanged, no validOUT.
//  4. 100 ns glitch high mid-word -> errorOUT, SYNC; next frame after gap decodes correctly.
//  5. Line held high 3 us -> single errorOUT; threshold edges: high 840 ns ->0, 860 ns ->1.
//  6. nResetIN low at bit 10 -> outputs 0; no decode until >=50 us low gap; then 0x123456 OK.
//  7. FORWARD_EN: frame 0x111111,0x222222 -> validOUT only for 0x111111; forwardOUT carries
//     0x222222 with 500/1200 ns highs.

Source files
------------

// File: rtl/ws2811_receiver.sv
`default_nettype none
// ============================================================================
//  Module      : ws2811_receiver
//  Description : Decodes a WS2811 single-wire NRZ pixel stream into 24-bit
//                words, MSB first. The high time of each pulse selects the
//                bit value. A long low gap marks the end of a frame (latch).
//                Malformed pulses and partial words are reported on errorOUT.
//  Optional    : WS2811_RX_FORWARD_EN - daisy-chain repeater mode. The first
//                word of each frame is consumed and reported. Every later bit
//                is regenerated on forwardOUT.
//  Ports       : clkIN      - system clock, all logic on the rising edge
//                nResetIN   - asynchronous active-low reset
//                dataIN     - raw serial line, asynchronous to clkIN
//                dataOUT    - last complete word, MSB = first bit received
//                validOUT   - 1-cycle pulse, dataOUT updated
//                latchOUT   - 1-cycle pulse, reset gap detected
//                errorOUT   - 1-cycle pulse, malformed pulse/partial word
//                busyOUT    - high while inside a frame
//                forwardOUT - regenerated stream (forward mode only)
//  Revision    : 1.0 - initial release
// ============================================================================
module ws2811_receiver #(
    parameter int CLOCK_SPEED   = 50_000_000,
    parameter int BIT_THRESH_NS = 850,
    parameter int MIN_HIGH_NS   = 200,
    parameter int MAX_HIGH_NS   = 2000,
    parameter int RESET_NS      = 50_000
) (
    input  logic        clkIN,
    input  logic        nResetIN,
    input  logic        dataIN,
    output logic [23:0] dataOUT,
    output logic        validOUT,
    output logic        latchOUT,
    output logic        errorOUT,
    output logic        busyOUT
`ifdef WS2811_RX_FORWARD_EN
    ,
    output logic        forwardOUT
`endif
);

    localparam int          c_MHZ            = CLOCK_SPEED / 1_000_000;
    localparam logic [15:0] c_BIT_THRESH_CLK = 16'(c_MHZ * BIT_THRESH_NS / 1000);
    localparam logic [15:0] c_MIN_HIGH_CLK   = 16'(c_MHZ * MIN_HIGH_NS / 1000);
    localparam logic [15:0] c_MAX_HIGH_CLK   = 16'(c_MHZ * MAX_HIGH_NS / 1000);
    localparam logic [15:0] c_RESET_CLK      = 16'(c_MHZ * RESET_NS / 1000);

    typedef enum logic [1:0] {
        ST_SYNC    = 2'd0,
        ST_IDLE    = 2'd1,
        ST_RX_HIGH = 2'd2,
        ST_RX_LOW  = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_next;

    logic        r_sync1;
    logic        r_sync2;
    logic        r_sync_d;
    logic        w_rise;
    logic        w_fall;
    logic        w_edge;

    logic [15:0] r_cnt;
    logic [15:0] w_len;

    logic [23:0] r_shift;
    logic [23:0] w_shift_next;
    logic [4:0]  r_bitcnt;

    logic        w_accept;
    logic        w_bit;
    logic        w_err;
    logic        w_latch;
    logic        w_word_done;
    logic        w_report;

    // ------------------------------------------------------------------
    // Input synchroniser and edge detection
    // ------------------------------------------------------------------
    always_ff @(posedge clkIN or negedge nResetIN) begin
        if (!nResetIN) begin
            r_sync1  <= 1'b0;
            r_sync2  <= 1'b0;
            r_sync_d <= 1'b0;
        end else begin
            r_sync1  <= dataIN;
            r_sync2  <= r_sync1;
            r_sync_d <= r_sync2;
        end
    end

    assign w_rise = r_sync2 & ~r_sync_d;
    assign w_fall = ~r_sync2 & r_sync_d;
    assign w_edge = w_rise | w_fall;

    // ------------------------------------------------------------------
    // Pulse-length counter: saturating, cleared on every synced edge.
    // r_cnt lags the true level length by one cycle (it is cleared on
    // the edge cycle itself), so w_len = r_cnt + 1 is the length in clocks
    // of the level that is ending or still running. All thresholds compare
    // against w_len, so a high of exactly N clocks is judged as N.
    // ------------------------------------------------------------------
    always_ff @(posedge clkIN or negedge nResetIN) begin
        if (!nResetIN) begin
            r_cnt <= 16'd0;
        end else if (w_edge) begin
            r_cnt <= 16'd0;
        end else if (r_cnt != 16'hFFFF) begin
            r_cnt <= r_cnt + 16'd1;
        end
    end

    assign w_len = (r_cnt == 16'hFFFF) ? r_cnt : (r_cnt + 16'd1);

    // ------------------------------------------------------------------
    // Frame state machine
    // ------------------------------------------------------------------
    always_ff @(posedge clkIN or negedge nResetIN) begin
        if (!nResetIN) begin
            r_state <= ST_SYNC;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_bit        = 1'b0;
        w_err        = 1'b0;
        w_latch      = 1'b0;
        case (r_state)
            ST_SYNC: begin
                // The edge cycle still carries the length of the previous
                // level, so it must not be mistaken for a finished gap.
                if (!r_sync2 && !w_edge && (w_len >= c_RESET_CLK)) begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (w_rise) begin
                    w_state_next = ST_RX_HIGH;
                end
            end
            ST_RX_HIGH: begin
                if (w_fall) begin
                    if ((w_len < c_MIN_HIGH_CLK) || (w_len > c_MAX_HIGH_CLK)) begin
                        w_err        = 1'b1;
                        w_state_next = ST_SYNC;
                    end else begin
                        w_accept     = 1'b1;
                        w_bit        = (w_len > c_BIT_THRESH_CLK);
                        w_state_next = ST_RX_LOW;
                    end
                end else if (w_len > c_MAX_HIGH_CLK) begin
                    // Stuck-high line: report once, then leave the frame.
                    w_err        = 1'b1;
                    w_state_next = ST_SYNC;
                end
            end
            ST_RX_LOW: begin
                if (w_rise) begin
                    w_state_next = ST_RX_HIGH;
                end else if (w_len >= c_RESET_CLK) begin
                    w_latch      = 1'b1;
                    w_err        = (r_bitcnt != 5'd0);
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_SYNC;
            end
        endcase
    end

    assign w_shift_next = {r_shift[22:0], w_bit};
    assign w_word_done  = w_accept && (r_bitcnt == 5'd23);

    // ------------------------------------------------------------------
    // Shift register, bit counter and output pulses
    // ------------------------------------------------------------------
    always_ff @(posedge clkIN or negedge nResetIN) begin
        if (!nResetIN) begin
            r_shift  <= 24'd0;
            r_bitcnt <= 5'd0;
            dataOUT  <= 24'd0;
            validOUT <= 1'b0;
            latchOUT <= 1'b0;
            errorOUT <= 1'b0;
        end else begin
            validOUT <= 1'b0;
            latchOUT <= w_latch;
            errorOUT <= w_err;
            if (w_accept) begin
                r_shift <= w_shift_next;
            end
            if (w_err) begin
                r_bitcnt <= 5'd0;
            end else if (w_accept) begin
                r_bitcnt <= w_word_done ? 5'd0 : (r_bitcnt + 5'd1);
            end
            if (w_word_done && w_report) begin
                dataOUT  <= w_shift_next;
                validOUT <= 1'b1;
            end
        end
    end

    assign busyOUT = (r_state == ST_RX_HIGH) || (r_state == ST_RX_LOW);

`ifdef WS2811_RX_FORWARD_EN
    // ------------------------------------------------------------------
    // Repeater: word 0 of each frame is consumed here, later bits are
    // regenerated with clean timing. A forwarded pulse starts on the synced
    // rising edge, giving a 3-clock lag. It ends after the short high time
    // once the input has fallen as a 0, or after the long high time once
    // the input has been seen as a 1. A 0 bit longer than the short time
    // keeps its own length, because the value is not known earlier.
    // ------------------------------------------------------------------
    localparam logic [15:0] c_FWD0_CLK = 16'(c_MHZ * 500 / 1000);
    localparam logic [15:0] c_FWD1_CLK = 16'(c_MHZ * 1200 / 1000);

    logic        r_fwd_en;
    logic        r_fwd;
    logic        r_fwd_one;
    logic [15:0] r_fwd_cnt;
    logic        w_fwd_one_set;
    logic        w_fwd_kill;
    logic        w_fwd_start;
    logic        w_fwd_end;

    assign w_report      = ~r_fwd_en;
    assign w_fwd_one_set = (r_state == ST_RX_HIGH) && (w_len > c_BIT_THRESH_CLK);
    assign w_fwd_kill    = w_err || w_latch ||
                           (w_state_next == ST_SYNC) || (w_state_next == ST_IDLE);
    assign w_fwd_start   = (r_state == ST_RX_LOW) && w_rise && r_fwd_en;
    assign w_fwd_end     = r_fwd_one ? (r_fwd_cnt >= c_FWD1_CLK)
                                     : (!w_fwd_one_set && !r_sync2 &&
                                        (r_fwd_cnt >= c_FWD0_CLK));

    always_ff @(posedge clkIN or negedge nResetIN) begin
        if (!nResetIN) begin
            r_fwd_en  <= 1'b0;
            r_fwd     <= 1'b0;
            r_fwd_one <= 1'b0;
            r_fwd_cnt <= 16'd0;
        end else begin
            if (w_err || w_latch) begin
                r_fwd_en <= 1'b0;
            end else if (w_word_done) begin
                r_fwd_en <= 1'b1;
            end

            if (w_fwd_kill) begin
                r_fwd     <= 1'b0;
                r_fwd_one <= 1'b0;
            end else if (w_fwd_start) begin
                r_fwd     <= 1'b1;
                r_fwd_one <= 1'b0;
                r_fwd_cnt <= 16'd1;
            end else if (r_fwd) begin
                r_fwd_cnt <= r_fwd_cnt + 16'd1;
                if (w_fwd_one_set) begin
                    r_fwd_one <= 1'b1;
                end
                if (w_fwd_end) begin
                    r_fwd <= 1'b0;
                end
            end
        end
    end

    assign forwardOUT = r_fwd;
`else
    assign w_report = 1'b1;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ws2811_receiver.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ws2811_receiver
//  Description : Directed self-checking bench for ws2811_receiver in its
//                default build. The clock runs at 50 MHz with 1 time unit
//                equal to 1 ns. Line changes fall on falling clock edges.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ws2811_receiver;

    logic        clk = 1'b0;
    logic        nResetIN;
    logic        dataIN;
    logic [23:0] dataOUT;
    logic        validOUT;
    logic        latchOUT;
    logic        errorOUT;
    logic        busyOUT;

    int n_tests = 0;
    int n_fail  = 0;

    // event monitor state
    int cyc         = 0;
    int n_valid     = 0;
    int n_latch     = 0;
    int n_err       = 0;
    int n_latch_err = 0;
    int valid_cyc   = 0;
    int latch_cyc   = 0;
    logic [23:0] words[$];

    // per-test baselines
    int b_valid, b_latch, b_err, b_le, b_q;

    always #10 clk = ~clk;

    ws2811_receiver dut (
        .clkIN    (clk),
        .nResetIN (nResetIN),
        .dataIN   (dataIN),
        .dataOUT  (dataOUT),
        .validOUT (validOUT),
        .latchOUT (latchOUT),
        .errorOUT (errorOUT),
        .busyOUT  (busyOUT)
    );

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (validOUT) begin
            n_valid   <= n_valid + 1;
            valid_cyc <= cyc;
            words.push_back(dataOUT);
        end
        if (latchOUT) begin
            n_latch   <= n_latch + 1;
            latch_cyc <= cyc;
        end
        if (errorOUT) begin
            n_err <= n_err + 1;
        end
        if (latchOUT && errorOUT) begin
            n_latch_err <= n_latch_err + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic snap();
        b_valid = n_valid;
        b_latch = n_latch;
        b_err   = n_err;
        b_le    = n_latch_err;
        b_q     = words.size();
    endtask

    task automatic line(input logic v, input int ns);
        dataIN = v;
        #(ns);
    endtask

    task automatic send_bit(input logic b);
        if (b) begin
            line(1'b1, 1200);
            line(1'b0, 1300);
        end else begin
            line(1'b1, 500);
            line(1'b0, 2000);
        end
    endtask

    task automatic send_word(input logic [23:0] w);
        for (int i = 23; i >= 0; i--) begin
            send_bit(w[i]);
        end
    endtask

    task automatic send_custom(input logic [23:0] w, input int h1, input int h0, input int lo);
        for (int i = 23; i >= 0; i--) begin
            line(1'b1, w[i] ? h1 : h0);
            line(1'b0, lo);
        end
    endtask

    initial begin
        logic [11:0] part;
        nResetIN = 1'b0;
        dataIN   = 1'b0;

        // ---- reset state
        #40;
        chk("rst_data",  32'(dataOUT),  32'h0);
        chk("rst_valid", 32'(validOUT), 32'h0);
        chk("rst_latch", 32'(latchOUT), 32'h0);
        chk("rst_err",   32'(errorOUT), 32'h0);
        chk("rst_busy",  32'(busyOUT),  32'h0);
        #60;
        nResetIN = 1'b1;

        // ---- 1: single frame after initial gap
        snap();
        line(1'b0, 55000);
        send_word(24'hA5C3F0);
        line(1'b0, 55000);
        chk("t1_valid_cnt", 32'(n_valid - b_valid), 32'd1);
        chk("t1_data",      32'(dataOUT),           32'hA5C3F0);
        chk("t1_latch_cnt", 32'(n_latch - b_latch), 32'd1);
        chk("t1_latch_gap", 32'(latch_cyc - valid_cyc), 32'd2500);
        chk("t1_err_cnt",   32'(n_err - b_err),     32'd0);
        chk("t1_idle_busy", 32'(busyOUT),           32'h0);

        // ---- 2: two words in one frame
        snap();
        send_word(24'hFFFFFF);
        chk("t2_busy_mid",  32'(busyOUT),           32'h1);
        send_word(24'h000001);
        line(1'b0, 55000);
        chk("t2_valid_cnt", 32'(n_valid - b_valid), 32'd2);
        chk("t2_word0",     32'(words[b_q]),        32'hFFFFFF);
        chk("t2_word1",     32'(words[b_q + 1]),    32'h000001);
        chk("t2_latch_cnt", 32'(n_latch - b_latch), 32'd1);
        chk("t2_err_cnt",   32'(n_err - b_err),     32'd0);

        // ---- 3: partial word then gap
        snap();
        part = 12'hABC;
        for (int i = 11; i >= 0; i--) begin
            send_bit(part[i]);
        end
        line(1'b0, 55000);
        chk("t3_latch_err", 32'(n_latch_err - b_le), 32'd1);
        chk("t3_err_cnt",   32'(n_err - b_err),      32'd1);
        chk("t3_latch_cnt", 32'(n_latch - b_latch),  32'd1);
        chk("t3_valid_cnt", 32'(n_valid - b_valid),  32'd0);
        chk("t3_data_hold", 32'(dataOUT),            32'h000001);

        // ---- 4: short glitch mid-word, then a clean frame
        snap();
        for (int i = 0; i < 6; i++) begin
            send_bit(1'(i % 2));
        end
        line(1'b1, 100);
        line(1'b0, 55000);
        chk("t4_glitch_err", 32'(n_err - b_err),     32'd1);
        chk("t4_no_latch",   32'(n_latch - b_latch), 32'd0);
        send_word(24'h5A5A5A);
        line(1'b0, 55000);
        chk("t4_valid_cnt", 32'(n_valid - b_valid), 32'd1);
        chk("t4_data",      32'(dataOUT),           32'h5A5A5A);
        chk("t4_latch_cnt", 32'(n_latch - b_latch), 32'd1);
        chk("t4_err_total", 32'(n_err - b_err),     32'd1);

        // ---- 5: stuck-high line, then threshold-edge pulses
        snap();
        line(1'b1, 3000);
        line(1'b0, 55000);
        chk("t5_stuck_err", 32'(n_err - b_err),     32'd1);
        chk("t5_no_valid",  32'(n_valid - b_valid), 32'd0);
        chk("t5_no_latch",  32'(n_latch - b_latch), 32'd0);
        snap();
        send_custom(24'hAAAAAA, 860, 840, 1000);
        line(1'b0, 55000);
        chk("t5_thr_valid", 32'(n_valid - b_valid), 32'd1);
        chk("t5_thr_data",  32'(dataOUT),           32'hAAAAAA);
        chk("t5_thr_err",   32'(n_err - b_err),     32'd0);

        // ---- 6: reset mid-frame
        for (int i = 0; i < 10; i++) begin
            send_bit(1'b1);
        end
        nResetIN = 1'b0;
        #40;
        chk("t6_rst_data",  32'(dataOUT),  32'h0);
        chk("t6_rst_busy",  32'(busyOUT),  32'h0);
        chk("t6_rst_valid", 32'(validOUT), 32'h0);
        #60;
        nResetIN = 1'b1;
        snap();
        line(1'b0, 10000);
        send_word(24'h654321);
        line(1'b0, 55000);
        chk("t6_nogap_valid", 32'(n_valid - b_valid), 32'd0);
        chk("t6_nogap_latch", 32'(n_latch - b_latch), 32'd0);
        chk("t6_nogap_err",   32'(n_err - b_err),     32'd0);
        chk("t6_nogap_data",  32'(dataOUT),           32'h0);
        send_word(24'h123456);
        line(1'b0, 55000);
        chk("t6_valid_cnt", 32'(n_valid - b_valid), 32'd1);
        chk("t6_data",      32'(dataOUT),           32'h123456);
        chk("t6_latch_cnt", 32'(n_latch - b_latch), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
